painterengine_gpu_dma_read_arbiter: RTL and testbench
=====================================================

# painterengine_gpu_dma_read_arbiter

Round-robin scheduler sharing the single GPU DMA read engine (`painterengine_gpu_dma_reader`) among four requesters. It latches one request's address and length, re-arms the reader by pulsing its active-low reset, and presents a one-hot route. It then waits for the reader's done/error and returns a per-channel completion or error pulse. It sits between the GPU pipeline stages and the reader's router/parameter inputs.

## Interface
- `RESET_PULSE_CYCLES`, default 2: cycles the reader is held in reset before each job (≥1).
- `WATCHDOG_CYCLES`, default 32'd1048576: max RUN cycles before forced error; 0 disables the watchdog.
- `i_wire_clock`  in  1  the only clock.
- `i_wire_reset`  in  1  reset; synchronous, active-high.
- `i_wire_req`  in  4  per-channel request level; held high until that channel's ack/err pulse.
- `i_wire_req_address`  in  128  channel k byte address in [32k+:32].
- `i_wire_req_length`  in  128  channel k length in 32-bit words, in [32k+:32].
- `o_wire_grant`  out  4  one-hot channel currently owning the reader; 0 when idle.
- `o_wire_ack`  out  4  one-cycle pulse: the granted job finished without error.
- `o_wire_err`  out  4  one-cycle pulse: the granted job failed (reader error or watchdog).
- `o_wire_busy`  out  1  high in any state other than IDLE.
- `o_wire_reader_resetn`  out  1  drives the reader's active-low reset.
- `o_wire_reader_router`  out  4  drives the reader's router input; equals `o_wire_grant`.
- `o_wire_reader_address`  out  128  only the granted slot carries the latched address; other slots are 0.
- `o_wire_reader_length`  out  128  same slot rule, carrying the latched length.
- `i_wire_reader_done`  in  1  reader done level.
- `i_wire_reader_error`  in  1  reader error level.

## Operation
- **Reset:** all outputs are 0, including `o_wire_reader_resetn`, so the reader is held in reset. The round-robin pointer is 0 and the state is IDLE.
- **FSM states:** IDLE, ARM, RUN, COMPLETE.
- **IDLE:**
  - If `i_wire_req` ≠ 0, pick the first asserted channel starting at the pointer, wrapping 3→0.
  - Latch that channel's address/length into internal 32-bit registers.
  - Set grant to the chosen channel, load the pulse counter with `RESET_PULSE_CYCLES`, and go to ARM.
- **ARM:** `reader_resetn`=0; router, address and length are driven stable. Decrement the counter; at 1, go to RUN.
- **RUN:**
  - `reader_resetn`=1. The reader samples its router at the first edge after release, so router, address and length stay constant throughout RUN.
  - The watchdog counter clears on RUN entry and increments each cycle.
  - `i_wire_reader_error`, or watchdog = `WATCHDOG_CYCLES` (when nonzero), sets the err flag → COMPLETE.
  - Otherwise `i_wire_reader_done` clears the err flag → COMPLETE.
  - Error has priority over done when both are asserted in the same cycle.
- **COMPLETE (one cycle):**
  - Pulse `o_wire_ack` or `o_wire_err` (mask = grant); drive `reader_resetn`=0.
  - Set pointer = granted index + 1 mod 4.
  - Clear grant, address and length outputs, then go to IDLE.
- Requests deasserted during ARM/RUN do not abort the job; the job runs to completion and ack/err still pulses.
- Zero-length or misaligned requests are not filtered here; the reader flags them and they surface as `o_wire_err`.
- Requester contract: drop `req` at the edge where ack/err is sampled high. A `req` still high in the following IDLE cycle is a new request.
- Synchronous reset during any state immediately returns to reset values: the reader is reset, no ack/err is emitted, and the pointer goes to 0.

## Timing
- **Latency:** req seen in IDLE at edge T → grant valid at T+1. `reader_resetn` rises at T+1+`RESET_PULSE_CYCLES`.
- done sampled at edge D → ack high in cycle D+1 → IDLE at D+2. Next grant at D+3 at the earliest.
- Per-job overhead: `RESET_PULSE_CYCLES` + 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `o_wire_ack` | `o_wire_err` is one-hot or zero, and is never asserted for 2 consecutive cycles.

## Test plan
- **Single request:** req=4'b0010, addr[63:32]=0x1000, len[63:32]=16. Required response:
  - grant=0010 at T+1; `reader_resetn` 0 for 2 cycles then 1.
  - `reader_address`[63:32]=0x1000, all other slots 0.
  - Model done after 20 cycles → ack=0010 for 1 cycle, grant→0.
- **Round robin:** req=4'b1111 held, with each channel dropped at its ack. Required response: grant order 0001, 0010, 0100, 1000, each with exactly one ack.
- **Fairness across wrap:** serve ch3, then assert req=1001. Required response: ch0 is granted next (pointer 0).
- **Error path:** the model raises error and done in the same cycle. Required response: err pulses for the granted channel, ack stays 0, next job proceeds normally.
- **Watchdog:** set `WATCHDOG_CYCLES`=50 and have the reader never finish. Required response: err pulse exactly 50 cycles after RUN entry, reader re-held in reset.
- **Reset mid-RUN:** assert `i_wire_reset` for 1 cycle during RUN. Required response:
  - Next cycle all outputs are 0, no ack/err pulse, and `reader_resetn`=0.
  - A subsequent req=0100 is granted normally with priority restarting at ch0.

Source files
------------

// File: rtl/painterengine_gpu_dma_read_arbiter.sv
// Round-robin arbiter that time-shares the single GPU DMA reader among four
// requesters: latch a job, pulse the reader's reset, run it, report ack/err.
module painterengine_gpu_dma_read_arbiter #(
    parameter int unsigned RESET_PULSE_CYCLES = 2,
    parameter logic [31:0] WATCHDOG_CYCLES    = 32'd1048576
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_reset,
    input  logic [3:0]   i_wire_req,
    input  logic [127:0] i_wire_req_address,
    input  logic [127:0] i_wire_req_length,
    output logic [3:0]   o_wire_grant,
    output logic [3:0]   o_wire_ack,
    output logic [3:0]   o_wire_err,
    output logic         o_wire_busy,
    output logic         o_wire_reader_resetn,
    output logic [3:0]   o_wire_reader_router,
    output logic [127:0] o_wire_reader_address,
    output logic [127:0] o_wire_reader_length,
    input  logic         i_wire_reader_done,
    input  logic         i_wire_reader_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_COMPLETE
    } state_t;

    state_t      r_state, w_state;
    logic [1:0]  r_ptr,   w_ptr;
    logic [1:0]  r_idx,   w_idx;
    logic [3:0]  r_grant, w_grant;
    logic [31:0] r_addr,  w_addr;
    logic [31:0] r_len,   w_len;
    logic [31:0] r_pulse, w_pulse;
    logic [31:0] r_wdog,  w_wdog;
    logic [3:0]  r_ack,   w_ack;
    logic [3:0]  r_err,   w_err;
    logic        r_busy,  w_busy;
    logic        r_resetn, w_resetn;

    logic        w_pick_valid;
    logic [1:0]  w_pick_idx;
    logic [1:0]  w_cand;
    logic [31:0] w_wdog_inc;
    logic        w_wdog_hit;

    // First asserted request at or after the pointer, wrapping 3 -> 0.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = r_ptr;
        w_cand       = r_ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            w_cand = r_ptr + 2'(i);
            if (!w_pick_valid && i_wire_req[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    assign w_wdog_inc = r_wdog + 32'd1;
    // Fires on the WATCHDOG_CYCLES-th cycle spent in RUN.
    assign w_wdog_hit = (WATCHDOG_CYCLES != 32'd0) && (w_wdog_inc == WATCHDOG_CYCLES);

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_idx   = r_idx;
        w_grant = r_grant;
        w_addr  = r_addr;
        w_len   = r_len;
        w_pulse = r_pulse;
        w_wdog  = r_wdog;
        w_ack   = '0;
        w_err   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state = ST_ARM;
                    w_idx   = w_pick_idx;
                    w_grant = 4'b0001 << w_pick_idx;
                    w_addr  = i_wire_req_address[{w_pick_idx, 5'b00000} +: 32];
                    w_len   = i_wire_req_length[{w_pick_idx, 5'b00000} +: 32];
                    w_pulse = 32'(RESET_PULSE_CYCLES);
                end
            end
            ST_ARM: begin
                if (r_pulse <= 32'd1) begin
                    w_state = ST_RUN;
                    w_wdog  = '0;
                end else begin
                    w_pulse = r_pulse - 32'd1;
                end
            end
            ST_RUN: begin
                w_wdog = w_wdog_inc;
                if (i_wire_reader_error || w_wdog_hit) begin
                    w_err   = r_grant;
                    w_state = ST_COMPLETE;
                end else if (i_wire_reader_done) begin
                    w_ack   = r_grant;
                    w_state = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                w_ptr   = r_idx + 2'd1;
                w_grant = '0;
                w_addr  = '0;
                w_len   = '0;
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
        w_resetn = (w_state == ST_RUN);
        w_busy   = (w_state != ST_IDLE);
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_grant  <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_pulse  <= '0;
            r_wdog   <= '0;
            r_ack    <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_resetn <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ptr    <= w_ptr;
            r_idx    <= w_idx;
            r_grant  <= w_grant;
            r_addr   <= w_addr;
            r_len    <= w_len;
            r_pulse  <= w_pulse;
            r_wdog   <= w_wdog;
            r_ack    <= w_ack;
            r_err    <= w_err;
            r_busy   <= w_busy;
            r_resetn <= w_resetn;
        end
    end

    // Only the granted slot carries the job; all others read as zero.
    always_comb begin
        o_wire_reader_address = '0;
        o_wire_reader_length  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (r_grant[k]) begin
                o_wire_reader_address[32*k +: 32] = r_addr;
                o_wire_reader_length[32*k +: 32]  = r_len;
            end
        end
    end

    assign o_wire_grant         = r_grant;
    assign o_wire_reader_router = r_grant;
    assign o_wire_ack           = r_ack;
    assign o_wire_err           = r_err;
    assign o_wire_busy          = r_busy;
    assign o_wire_reader_resetn = r_resetn;

endmodule

// File: tb/tb_painterengine_gpu_dma_read_arbiter.sv
// Directed bench for the DMA read arbiter: single job, round robin, wrap,
// error priority, watchdog and mid-run reset, with hand-computed expectations.
module tb_painterengine_gpu_dma_read_arbiter;

    logic         i_wire_clock;
    logic         i_wire_reset;
    logic [3:0]   i_wire_req;
    logic [127:0] i_wire_req_address;
    logic [127:0] i_wire_req_length;
    logic [3:0]   o_wire_grant;
    logic [3:0]   o_wire_ack;
    logic [3:0]   o_wire_err;
    logic         o_wire_busy;
    logic         o_wire_reader_resetn;
    logic [3:0]   o_wire_reader_router;
    logic [127:0] o_wire_reader_address;
    logic [127:0] o_wire_reader_length;
    logic         i_wire_reader_done;
    logic         i_wire_reader_error;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    painterengine_gpu_dma_read_arbiter #(
        .RESET_PULSE_CYCLES(2),
        .WATCHDOG_CYCLES   (32'd50)
    ) u_dut (
        .i_wire_clock         (i_wire_clock),
        .i_wire_reset         (i_wire_reset),
        .i_wire_req           (i_wire_req),
        .i_wire_req_address   (i_wire_req_address),
        .i_wire_req_length    (i_wire_req_length),
        .o_wire_grant         (o_wire_grant),
        .o_wire_ack           (o_wire_ack),
        .o_wire_err           (o_wire_err),
        .o_wire_busy          (o_wire_busy),
        .o_wire_reader_resetn (o_wire_reader_resetn),
        .o_wire_reader_router (o_wire_reader_router),
        .o_wire_reader_address(o_wire_reader_address),
        .o_wire_reader_length (o_wire_reader_length),
        .i_wire_reader_done   (i_wire_reader_done),
        .i_wire_reader_error  (i_wire_reader_error)
    );

    initial i_wire_clock = 1'b0;
    always #5 i_wire_clock = ~i_wire_clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_wire_clock);
        #1;
    endtask

    // One complete job from the IDLE sampling edge to the return to IDLE.
    task automatic serve(input string tag, input logic [3:0] exp_g, input int unsigned exp_k,
                         input logic [31:0] exp_addr, input logic [31:0] exp_len,
                         input int unsigned run_cycles, input logic fail_job);
        logic [127:0] bus_a;
        logic [127:0] bus_l;
        bus_a = 128'(exp_addr) << (32 * exp_k);
        bus_l = 128'(exp_len) << (32 * exp_k);
        step();
        check({tag, "/grant"},  128'(o_wire_grant), 128'(exp_g));
        check({tag, "/router"}, 128'(o_wire_reader_router), 128'(exp_g));
        check({tag, "/busy"},   128'(o_wire_busy), 128'(1'b1));
        check({tag, "/rstn0"},  128'(o_wire_reader_resetn), 128'(1'b0));
        check({tag, "/addr"},   o_wire_reader_address, bus_a);
        check({tag, "/len"},    o_wire_reader_length, bus_l);
        step();
        check({tag, "/rstn1"},  128'(o_wire_reader_resetn), 128'(1'b0));
        step();
        check({tag, "/rstn_up"}, 128'(o_wire_reader_resetn), 128'(1'b1));
        repeat (run_cycles) step();
        check({tag, "/quiet"}, 128'(o_wire_ack | o_wire_err), 128'(0));
        check({tag, "/addr_run"}, o_wire_reader_address, bus_a);
        if (fail_job) begin
            i_wire_reader_error = 1'b1;
            i_wire_reader_done  = 1'b1;
        end else begin
            i_wire_reader_done  = 1'b1;
        end
        step();
        check({tag, "/ack"},   128'(o_wire_ack), fail_job ? 128'(0) : 128'(exp_g));
        check({tag, "/err"},   128'(o_wire_err), fail_job ? 128'(exp_g) : 128'(0));
        check({tag, "/rstn_c"}, 128'(o_wire_reader_resetn), 128'(1'b0));
        i_wire_req          = i_wire_req & ~exp_g;
        i_wire_reader_done  = 1'b0;
        i_wire_reader_error = 1'b0;
        step();
        check({tag, "/grant0"}, 128'(o_wire_grant), 128'(0));
        check({tag, "/pulse1"}, 128'(o_wire_ack | o_wire_err), 128'(0));
        check({tag, "/idle"},   128'(o_wire_busy), 128'(1'b0));
        check({tag, "/addr0"},  o_wire_reader_address, 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        i_wire_reset        = 1'b1;
        i_wire_req          = '0;
        i_wire_reader_done  = 1'b0;
        i_wire_reader_error = 1'b0;
        i_wire_req_address  = {32'h4000_0300, 32'h3000_0200, 32'h0000_1000, 32'h1000_0000};
        i_wire_req_length   = {32'd64, 32'd32, 32'd16, 32'd8};
        step();
        step();
        check("rst/grant", 128'(o_wire_grant), 128'(0));
        check("rst/ack",   128'(o_wire_ack), 128'(0));
        check("rst/err",   128'(o_wire_err), 128'(0));
        check("rst/busy",  128'(o_wire_busy), 128'(0));
        check("rst/rstn",  128'(o_wire_reader_resetn), 128'(0));
        check("rst/addr",  o_wire_reader_address, 128'(0));
        check("rst/len",   o_wire_reader_length, 128'(0));
        i_wire_reset = 1'b0;

        i_wire_req = 4'b0010;
        serve("single", 4'b0010, 1, 32'h0000_1000, 32'd16, 20, 1'b0);

        i_wire_reset = 1'b1;
        step();
        i_wire_reset = 1'b0;
        i_wire_req = 4'b1111;
        serve("rr0", 4'b0001, 0, 32'h1000_0000, 32'd8,  3, 1'b0);
        serve("rr1", 4'b0010, 1, 32'h0000_1000, 32'd16, 4, 1'b0);
        serve("rr2", 4'b0100, 2, 32'h3000_0200, 32'd32, 5, 1'b0);
        serve("rr3", 4'b1000, 3, 32'h4000_0300, 32'd64, 6, 1'b0);

        i_wire_req = 4'b1001;
        serve("wrap0", 4'b0001, 0, 32'h1000_0000, 32'd8,  2, 1'b0);
        serve("wrap3", 4'b1000, 3, 32'h4000_0300, 32'd64, 2, 1'b0);

        i_wire_req = 4'b0100;
        serve("errjob", 4'b0100, 2, 32'h3000_0200, 32'd32, 4, 1'b1);
        i_wire_req = 4'b0010;
        serve("afterr", 4'b0010, 1, 32'h0000_1000, 32'd16, 4, 1'b0);

        // Pointer is 2; ch0 is the only requester and the reader never finishes.
        i_wire_req = 4'b0001;
        step();
        check("wd/grant", 128'(o_wire_grant), 128'(4'b0001));
        step();
        step();
        check("wd/rstn_up", 128'(o_wire_reader_resetn), 128'(1'b1));
        repeat (49) step();
        check("wd/early", 128'(o_wire_err | o_wire_ack), 128'(0));
        check("wd/run49", 128'(o_wire_reader_resetn), 128'(1'b1));
        step();
        check("wd/err",  128'(o_wire_err), 128'(4'b0001));
        check("wd/ack",  128'(o_wire_ack), 128'(0));
        check("wd/rstn", 128'(o_wire_reader_resetn), 128'(1'b0));
        i_wire_req = 4'b0000;
        step();
        check("wd/grant0", 128'(o_wire_grant), 128'(0));
        check("wd/pulse1", 128'(o_wire_err), 128'(0));

        // Pointer is 1; reset lands in the middle of RUN.
        i_wire_req = 4'b1000;
        step();
        check("mid/grant", 128'(o_wire_grant), 128'(4'b1000));
        step();
        step();
        check("mid/rstn_up", 128'(o_wire_reader_resetn), 128'(1'b1));
        repeat (5) step();
        i_wire_reset = 1'b1;
        i_wire_req   = 4'b0000;
        i_wire_reader_done = 1'b1;
        step();
        check("mid/grant", 128'(o_wire_grant), 128'(0));
        check("mid/ack",   128'(o_wire_ack), 128'(0));
        check("mid/err",   128'(o_wire_err), 128'(0));
        check("mid/busy",  128'(o_wire_busy), 128'(0));
        check("mid/rstn",  128'(o_wire_reader_resetn), 128'(0));
        check("mid/addr",  o_wire_reader_address, 128'(0));
        i_wire_reset = 1'b0;
        i_wire_reader_done = 1'b0;
        step();
        check("mid/nopulse", 128'(o_wire_ack | o_wire_err), 128'(0));
        check("mid/idle",    128'(o_wire_busy), 128'(0));

        i_wire_req = 4'b0101;
        serve("post0", 4'b0001, 0, 32'h1000_0000, 32'd8,  3, 1'b0);
        serve("post2", 4'b0100, 2, 32'h3000_0200, 32'd32, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
